// File: rtl/coffee_machine_ctrl.sv
// Coin-operated drink controller: credit accumulation, price check, timed valve dispense, change display.
// Optional COIN_SYNC_EN adds a 2-flop synchronizer on coin_100, coin_500 and confirm.
module coffee_machine_ctrl #(
  parameter int unsigned DISPENSE_CYCLES = 4,
  parameter int unsigned DONE_CYCLES     = 2,
  parameter int unsigned CREDIT_MAX      = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       coin_100,
  input  logic       coin_500,
  input  logic [2:0] coffee_type,
  input  logic       confirm,
  output logic [6:0] total_coins_display,
  output logic [6:0] change_display,
  output logic       water,
  output logic       coffee,
  output logic       sugar,
  output logic       milk,
  output logic       chocolate,
  output logic       finished
);

  typedef enum logic [1:0] {S_IDLE, S_DISPENSE, S_DONE} state_t;

  localparam int unsigned CNT_MAX = (DISPENSE_CYCLES > DONE_CYCLES) ? DISPENSE_CYCLES : DONE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_credit, r_change;
  logic [2:0]       r_type;
  logic             r_c100_prev, r_c500_prev;
  logic             w_coin_100, w_coin_500, w_confirm;

`ifdef COIN_SYNC_EN
  logic [1:0] r_c100_sync, r_c500_sync, r_conf_sync;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_c100_sync <= 2'b11;
      r_c500_sync <= 2'b11;
      r_conf_sync <= 2'b00;
    end else begin
      r_c100_sync <= {r_c100_sync[0], coin_100};
      r_c500_sync <= {r_c500_sync[0], coin_500};
      r_conf_sync <= {r_conf_sync[0], confirm};
    end
  end

  assign w_coin_100 = r_c100_sync[1];
  assign w_coin_500 = r_c500_sync[1];
  assign w_confirm  = r_conf_sync[1];
`else
  assign w_coin_100 = coin_100;
  assign w_coin_500 = coin_500;
  assign w_confirm  = confirm;
`endif

  function automatic logic [3:0] price_of(input logic [2:0] t);
    case (t)
      3'b001:  price_of = 4'd3;
      3'b010:  price_of = 4'd5;
      3'b011:  price_of = 4'd6;
      3'b100:  price_of = 4'd4;
      default: price_of = 4'd0;
    endcase
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // A coin counts on the edge where it is seen low after having been seen high.
  logic       w_c100_hit, w_c500_hit, w_accept;
  logic [3:0] w_coin_add, w_price;
  logic [4:0] w_credit_sum;

  assign w_c100_hit   = r_c100_prev & ~w_coin_100;
  assign w_c500_hit   = r_c500_prev & ~w_coin_500;
  assign w_coin_add   = (w_c100_hit ? 4'd1 : 4'd0) + (w_c500_hit ? 4'd5 : 4'd0);
  assign w_credit_sum = {1'b0, r_credit} + {1'b0, w_coin_add};
  assign w_price      = price_of(coffee_type);
  assign w_accept     = (r_state == S_IDLE) && w_confirm && (w_price != 4'd0) && (r_credit >= w_price);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_c100_prev <= 1'b1;
      r_c500_prev <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_c100_prev <= w_coin_100;
      r_c500_prev <= w_coin_500;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_credit <= '0;
      r_change <= '0;
      r_type   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_change <= r_credit - w_price;
            r_type   <= coffee_type;
          end else if (w_credit_sum <= 5'(CREDIT_MAX)) begin
            r_credit <= w_credit_sum[3:0];
          end
        end
        S_DONE: begin
          if (w_state_nxt == S_IDLE) begin
            r_credit <= '0;
            r_change <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    water       = 1'b0;
    coffee      = 1'b0;
    sugar       = 1'b0;
    milk        = 1'b0;
    chocolate   = 1'b0;
    finished    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_DISPENSE;
          w_cnt_nxt   = '0;
        end
      end
      S_DISPENSE: begin
        case (r_type)
          3'b001: begin water = 1'b1; coffee = 1'b1; end
          3'b010: begin water = 1'b1; coffee = 1'b1; milk = 1'b1; sugar = 1'b1; end
          3'b011: begin water = 1'b1; coffee = 1'b1; milk = 1'b1; chocolate = 1'b1; sugar = 1'b1; end
          3'b100: begin water = 1'b1; milk = 1'b1; chocolate = 1'b1; sugar = 1'b1; end
          default: ;
        endcase
        if (r_cnt == CNT_W'(DISPENSE_CYCLES - 1)) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DONE: begin
        finished = 1'b1;
        if (r_cnt == CNT_W'(DONE_CYCLES - 1)) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign total_coins_display = seg7(r_credit);
  assign change_display      = (r_state == S_IDLE) ? seg7(4'd0) : seg7(r_change);

endmodule

// File: tb/tb_coffee_machine_ctrl.sv
// Scoreboard bench for coffee_machine_ctrl (default build): a purchase-level model predicts
// every cycle's outputs; a negedge monitor pops and compares them.
module tb_coffee_machine_ctrl;

  localparam int DISP = 4;
  localparam int DONE = 2;
  localparam int CMAX = 9;

  logic       clock = 1'b0;
  logic       reset, coin_100, coin_500, confirm;
  logic [2:0] coffee_type;
  logic [6:0] total_coins_display, change_display;
  logic       water, coffee, sugar, milk, chocolate, finished;

  always #5 clock = ~clock;

  coffee_machine_ctrl dut (
    .clock               (clock),
    .reset               (reset),
    .coin_100            (coin_100),
    .coin_500            (coin_500),
    .coffee_type         (coffee_type),
    .confirm             (confirm),
    .total_coins_display (total_coins_display),
    .change_display      (change_display),
    .water               (water),
    .coffee              (coffee),
    .sugar               (sugar),
    .milk                (milk),
    .chocolate           (chocolate),
    .finished            (finished)
  );

  typedef struct packed {
    logic [6:0] total;
    logic [6:0] change;
    logic [4:0] valves;  // {water, coffee, sugar, milk, chocolate}
    logic       fin;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: credit, latched change/drink, and cycles left until back in IDLE.
  int         m_credit, m_change, m_busy;
  logic [2:0] m_type;
  logic       m_p100, m_p500;

  function automatic int price(input logic [2:0] t);
    case (t)
      3'd1: return 3;
      3'd2: return 5;
      3'd3: return 6;
      3'd4: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [4:0] recipe(input logic [2:0] t);
    case (t)
      3'd1: return 5'b11000;
      3'd2: return 5'b11110;
      3'd3: return 5'b11111;
      3'd4: return 5'b10111;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic logic [6:0] seg(input int v);
    logic [6:0] tab [10];
    tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return tab[v];
  endfunction

  // Drive one cycle's inputs, advance the model across the coming edge, queue the expectation.
  task automatic cycle(input logic rst, input logic c100, input logic c500,
                       input logic conf, input logic [2:0] typ);
    exp_t e;
    int   add;
    reset = rst; coin_100 = c100; coin_500 = c500; confirm = conf; coffee_type = typ;
    if (rst) begin
      m_credit = 0; m_change = 0; m_busy = 0; m_type = 3'd0; m_p100 = 1'b1; m_p500 = 1'b1;
    end else begin
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_credit = 0;
          m_change = 0;
        end
      end else if (conf && price(typ) > 0 && m_credit >= price(typ)) begin
        m_busy   = DISP + DONE;
        m_change = m_credit - price(typ);
        m_type   = typ;
      end else begin
        add = ((m_p100 && !c100) ? 1 : 0) + ((m_p500 && !c500) ? 5 : 0);
        if (m_credit + add <= CMAX) m_credit += add;
      end
      m_p100 = c100;
      m_p500 = c500;
    end
    e.total  = seg(m_credit);
    e.change = (m_busy > 0) ? seg(m_change) : seg(0);
    e.valves = (m_busy > DONE) ? recipe(m_type) : 5'b00000;
    e.fin    = (m_busy > 0) && (m_busy <= DONE);
    @(posedge clock);
    sb_q.push_back(e);
    #1;
  endtask

  task automatic idle(input int n, input logic [2:0] typ);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, typ);
  endtask

  task automatic press(input bit use100, input bit use500, input int low_cycles, input logic [2:0] typ);
    for (int i = 0; i < low_cycles; i++) cycle(1'b0, !use100, !use500, 1'b0, typ);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, typ);
  endtask

  task automatic buy(input logic [2:0] typ);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, typ);
    idle(8, typ);
  endtask

  // Monitor: compares one queued expectation per cycle, away from the active edge.
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clock);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        a = '{total_coins_display, change_display, {water, coffee, sugar, milk, chocolate}, finished};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL outputs @%0t: got total=%h change=%h valves=%b fin=%b, expected total=%h change=%h valves=%b fin=%b",
                   $time, a.total, a.change, a.valves, a.fin, e.total, e.change, e.valves, e.fin);
        end
      end
    end
  end

  initial begin
    int n, kind, trail, rst_at;
    logic [2:0] typ;

    cycle(1'b1, 1'b1, 1'b1, 1'b0, 3'd1);
    idle(2, 3'd1);

    // Espresso with exact credit.
    repeat (3) press(1'b1, 1'b0, 1, 3'd1);
    buy(3'd1);

    // Cappuccino from 6 credit, change 1.
    press(1'b0, 1'b1, 1, 3'd2);
    press(1'b1, 1'b0, 1, 3'd2);
    buy(3'd2);

    // Second 500 overflows and is rejected; long hold counts once.
    press(1'b0, 1'b1, 3, 3'd0);
    press(1'b0, 1'b1, 1, 3'd0);
    press(1'b1, 1'b1, 1, 3'd0);

    // Insufficient credit, then invalid code at full credit.
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 3'd1);
    repeat (2) press(1'b1, 1'b0, 1, 3'd1);
    buy(3'd1);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 3'd7);
    press(1'b1, 1'b1, 1, 3'd7);
    repeat (3) press(1'b1, 1'b0, 1, 3'd7);
    buy(3'd7);

    // Reset in the middle of dispensing a mocha bought with full credit.
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 3'd3);
    idle(2, 3'd3);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 3'd3);
    idle(2, 3'd3);

    // Randomized sessions; confirm and drink code wander while busy.
    repeat (80) begin
      n = $urandom_range(0, 4);
      for (int i = 0; i < n; i++) begin
        kind = $urandom_range(0, 2);
        press(kind != 1, kind != 0, $urandom_range(1, 3), 3'($urandom_range(0, 7)));
      end
      typ = 3'($urandom_range(0, 7));
      for (int i = 0; i < int'($urandom_range(1, 3)); i++) cycle(1'b0, 1'b1, 1'b1, 1'b1, typ);
      trail  = 9;
      rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 8)) : -1;
      for (int i = 0; i < trail; i++)
        cycle(i == rst_at, 1'b1, 1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clock);
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
    end
    @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
